stream_split: RTL and testbench

//  Versat functional unit; inverse of the time-multiplexing merge unit.

---
 rtl/stream_split_pkg.sv | 14 +
 rtl/stream_split_if.sv | 31 +++
 rtl/stream_split_ctrl.sv | 88 ++++++++
 rtl/stream_split.sv | 59 +++++
 tb/tb_stream_split.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/stream_split_pkg.sv
// Shared constants and FSM encoding for the stream splitter.
package stream_split_pkg;

    localparam int NUM_LANES = 16;
    localparam int LANE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/stream_split_if.sv
// Configuration, stream input and per-lane outputs of the stream splitter.
interface stream_split_if
    import stream_split_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 32
);
    logic              run;
    logic [DATA_W-1:0] in0;
    logic [DELAY_W-1:0] delay0;
    logic [LANE_W-1:0] lanes0;
    logic              done;
    logic [DATA_W-1:0] out0,  out1,  out2,  out3;
    logic [DATA_W-1:0] out4,  out5,  out6,  out7;
    logic [DATA_W-1:0] out8,  out9,  out10, out11;
    logic [DATA_W-1:0] out12, out13, out14, out15;

    modport master (
        output run, in0, delay0, lanes0,
        input  done,
        input  out0, out1, out2, out3, out4, out5, out6, out7,
        input  out8, out9, out10, out11, out12, out13, out14, out15
    );

    modport slave (
        input  run, in0, delay0, lanes0,
        output done,
        output out0, out1, out2, out3, out4, out5, out6, out7,
        output out8, out9, out10, out11, out12, out13, out14, out15
    );
endinterface

// File: rtl/stream_split_ctrl.sv
// Sequencer: start-delay countdown, lane counter and done flag; emits one-hot
// lane write enables for the lane registers in the top.
module stream_split_ctrl
    import stream_split_pkg::*;
#(
    parameter int DELAY_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic [DELAY_W-1:0]   i_delay0,
    input  logic [LANE_W-1:0]    i_lanes0,
    output logic [NUM_LANES-1:0] o_we,
    output logic                 o_done
);

    state_t              r_state,   w_state_nxt;
    logic [DELAY_W-1:0]  r_delay,   w_delay_nxt;
    logic [LANE_W-1:0]   r_counter, w_counter_nxt;
    logic [LANE_W-1:0]   r_nlanes,  w_nlanes_nxt;
    logic                r_done,    w_done_nxt;
    logic                w_capture;
    logic [LANE_W-1:0]   w_last;

    // Lane count 0 means 16, so the last index wraps naturally to 15.
    assign w_last = r_nlanes - LANE_W'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_delay   <= '0;
            r_counter <= '0;
            r_nlanes  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_delay   <= w_delay_nxt;
            r_counter <= w_counter_nxt;
            r_nlanes  <= w_nlanes_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // NOTE: every value written here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_delay_nxt   = r_delay;
        w_counter_nxt = r_counter;
        w_nlanes_nxt  = r_nlanes;
        w_done_nxt    = r_done;
        w_capture     = 1'b0;

        if (i_run) begin
            w_state_nxt   = ST_WAIT;
            w_delay_nxt   = i_delay0;
            w_counter_nxt = '0;
            w_nlanes_nxt  = i_lanes0;
            w_done_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_delay != '0) begin
                        w_delay_nxt = r_delay - DELAY_W'(1);
                    end else begin
                        w_capture = 1'b1;
                    end
                end
                ST_CAPTURE: w_capture = 1'b1;
                default: ;
            endcase

            if (w_capture) begin
                if (r_counter == w_last) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt   = ST_CAPTURE;
                    w_counter_nxt = r_counter + LANE_W'(1);
                end
            end
        end
    end

    assign o_we   = w_capture ? (NUM_LANES'(1) << r_counter) : '0;
    assign o_done = r_done;

endmodule

// File: rtl/stream_split.sv
// Stream splitter: distributes consecutive in0 samples over up to 16 held lanes
// after a programmable start delay.
module stream_split
    import stream_split_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    stream_split_if.slave  bus
);

    logic [NUM_LANES-1:0] w_we;
    logic                 w_done;
    logic [DATA_W-1:0]    r_lane [NUM_LANES];

    stream_split_ctrl #(
        .DELAY_W (DELAY_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .i_run    (bus.run),
        .i_delay0 (bus.delay0),
        .i_lanes0 (bus.lanes0),
        .o_we     (w_we),
        .o_done   (w_done)
    );

    // NOTE: lane registers carry a reset because the outputs must read zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_LANES; k++) r_lane[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (w_we[k]) r_lane[k] <= bus.in0;
            end
        end
    end

    assign bus.done  = w_done;
    assign bus.out0  = r_lane[0];
    assign bus.out1  = r_lane[1];
    assign bus.out2  = r_lane[2];
    assign bus.out3  = r_lane[3];
    assign bus.out4  = r_lane[4];
    assign bus.out5  = r_lane[5];
    assign bus.out6  = r_lane[6];
    assign bus.out7  = r_lane[7];
    assign bus.out8  = r_lane[8];
    assign bus.out9  = r_lane[9];
    assign bus.out10 = r_lane[10];
    assign bus.out11 = r_lane[11];
    assign bus.out12 = r_lane[12];
    assign bus.out13 = r_lane[13];
    assign bus.out14 = r_lane[14];
    assign bus.out15 = r_lane[15];

endmodule

// File: tb/tb_stream_split.sv
// Self-checking bench for stream_split: directed scenarios plus random runs,
// compared every cycle against a schedule-based reference model.
module tb_stream_split;

    localparam int DW = 32;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    stream_split_if #(.DATA_W(DW), .DELAY_W(LW)) bus ();

    stream_split #(.DATA_W(DW), .DELAY_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] w_out [16];
    assign w_out[0]  = bus.out0;
    assign w_out[1]  = bus.out1;
    assign w_out[2]  = bus.out2;
    assign w_out[3]  = bus.out3;
    assign w_out[4]  = bus.out4;
    assign w_out[5]  = bus.out5;
    assign w_out[6]  = bus.out6;
    assign w_out[7]  = bus.out7;
    assign w_out[8]  = bus.out8;
    assign w_out[9]  = bus.out9;
    assign w_out[10] = bus.out10;
    assign w_out[11] = bus.out11;
    assign w_out[12] = bus.out12;
    assign w_out[13] = bus.out13;
    assign w_out[14] = bus.out14;
    assign w_out[15] = bus.out15;

    // Reference model: a run at edge T schedules lane k for edge T+1+delay0+k.
    logic [DW-1:0] m_out [16];
    logic          m_done;
    logic          m_active;
    longint        m_edge;
    longint        m_start;
    int            m_n;

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_out[k] = '0;
        m_done   = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic model_edge();
        longint k;
        m_edge++;
        if (rst) begin
            if (bus.run) begin
                m_start  = m_edge + 1 + longint'(bus.delay0);
                m_n      = (bus.lanes0 == 0) ? 16 : int'(bus.lanes0);
                m_active = 1'b1;
                m_done   = 1'b0;
            end else if (m_active && m_edge >= m_start) begin
                k = m_edge - m_start;
                m_out[k] = bus.in0;
                if (k == longint'(m_n - 1)) begin
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("done", DW'(bus.done), DW'(m_done));
        for (int k = 0; k < 16; k++) check($sformatf("out%0d", k), w_out[k], m_out[k]);
    endtask

    task automatic tick();
        bus.in0 = $urandom;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_cfg(input logic [LW-1:0] d, input logic [3:0] l);
        bus.run    = 1'b1;
        bus.delay0 = d;
        bus.lanes0 = l;
        tick();
        bus.run    = 1'b0;
        bus.delay0 = LW'($urandom);
        bus.lanes0 = 4'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", DW'(bus.done), DW'(1));
    endtask

    initial begin
        m_edge     = 0;
        m_start    = 0;
        m_n        = 0;
        rst        = 1'b0;
        bus.run    = 1'b0;
        bus.in0    = '0;
        bus.delay0 = '0;
        bus.lanes0 = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycles(3);

        // All 16 lanes, no delay
        run_cfg(8'd0, 4'd0);
        wait_done(40);
        cycles(3);

        // Four lanes after three idle cycles
        run_cfg(8'd3, 4'd4);
        wait_done(20);
        cycles(2);

        // Single lane, then hold for 20 cycles
        run_cfg(8'd5, 4'd1);
        wait_done(20);
        cycles(20);

        // Restart on the second capture edge of an eight-lane run
        run_cfg(8'd2, 4'd8);
        cycles(3);
        run_cfg(8'd2, 4'd8);
        wait_done(30);
        cycles(2);

        // Asynchronous reset in the middle of capture
        run_cfg(8'd1, 4'd0);
        cycles(5);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        cycles(3);
        rst = 1'b1;
        cycles(6);

        // Maximum delay must not underflow or capture early
        run_cfg(8'd255, 4'd2);
        wait_done(300);
        cycles(2);

        // Random runs, some restarting mid-capture
        for (int r = 0; r < 8; r++) begin
            run_cfg(LW'($urandom_range(0, 4)), 4'($urandom));
            cycles($urandom_range(1, 20));
        end
        run_cfg(8'd1, 4'd3);
        wait_done(20);
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
